// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection frame scheduler.
package edge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam int TAPS  = 9;
  localparam int TAP_W = 8;

  localparam logic KERNEL_SOBEL   = 1'b0;
  localparam logic KERNEL_PREWITT = 1'b1;

endpackage

// File: rtl/edge_pos_counter.sv
// Raster position tracker: pixel index plus row/column counters, border and last-pixel flags.
module edge_pos_counter #(
  parameter int WIDTH  = 45,
  parameter int HEIGHT = 45,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] p,
  output logic              border,
  output logic              last
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [ADDR_W-1:0] p_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_reg   <= '0;
      col_reg <= '0;
      row_reg <= '0;
    end else if (clr) begin
      p_reg   <= '0;
      col_reg <= '0;
      row_reg <= '0;
    end else if (adv && !last) begin
      // Holding at the final pixel keeps p inside the frame.
      p_reg <= p_reg + 1'b1;
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign p      = p_reg;
  assign last   = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
  assign border = (row_reg == '0) || (row_reg == ROW_LAST) ||
                  (col_reg == '0) || (col_reg == COL_LAST);

endmodule

// File: rtl/edge_frame_scheduler.sv
// Walks a frame in raster order: zeroes border pixels, gathers 3x3 windows for
// interior pixels, hands them to the edge engine and writes back its result.
module edge_frame_scheduler
  import edge_pkg::*;
#(
  parameter int WIDTH  = 45,
  parameter int HEIGHT = 45,
  parameter int ADDR_W = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kernel_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [TAPS*TAP_W-1:0] win_data,
  output logic                  win_kernel,
  input  logic                  res_valid,
  input  logic [7:0]            res_pixel,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data
);

  localparam logic [3:0] TAP_CNT = 4'(TAPS);

  state_t            state_reg;
  logic              busy_reg;
  logic              kernel_reg;
  logic [3:0]        fetch_cnt_reg;
  logic [1:0]        fetch_col_reg;
  logic [ADDR_W-1:0] fetch_addr_reg;
  logic [7:0]        res_reg;

  logic [ADDR_W-1:0] p;
  logic              border;
  logic              last;
  logic              pos_clr;
  logic              pos_adv;

  assign pos_clr = (state_reg == ST_IDLE) && start;
  assign pos_adv = ((state_reg == ST_SCAN) && border) || (state_reg == ST_WRITE);

  edge_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .clr    (pos_clr),
    .adv    (pos_adv),
    .p      (p),
    .border (border),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      busy_reg       <= 1'b0;
      kernel_reg     <= 1'b0;
      fetch_cnt_reg  <= '0;
      fetch_col_reg  <= '0;
      fetch_addr_reg <= '0;
      res_reg        <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg  <= ST_SCAN;
            busy_reg   <= 1'b1;
            kernel_reg <= kernel_sel;
          end
        end
        ST_SCAN: begin
          if (border) begin
            if (last) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
            end
          end else begin
            state_reg      <= ST_FETCH;
            fetch_cnt_reg  <= '0;
            fetch_col_reg  <= '0;
            fetch_addr_reg <= p - ADDR_W'(WIDTH + 1);
          end
        end
        ST_FETCH: begin
          // Cycle 0 issues the first read; cycle 9 only captures the last tap.
          fetch_cnt_reg <= fetch_cnt_reg + 4'd1;
          if (fetch_col_reg == 2'd2) begin
            fetch_col_reg  <= '0;
            fetch_addr_reg <= fetch_addr_reg + ADDR_W'(WIDTH - 2);
          end else begin
            fetch_col_reg  <= fetch_col_reg + 2'd1;
            fetch_addr_reg <= fetch_addr_reg + 1'b1;
          end
          if (fetch_cnt_reg == TAP_CNT) begin
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (win_ready) begin
            state_reg <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (res_valid) begin
            res_reg   <= res_pixel;
            state_reg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (last) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= ST_SCAN;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Each tap register captures the read data returned for its own fetch slot.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    logic [TAP_W-1:0] tap_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tap_reg <= '0;
      end else if ((state_reg == ST_FETCH) && (fetch_cnt_reg == 4'(gi + 1))) begin
        tap_reg <= rd_data;
      end
    end

    assign win_data[gi*TAP_W +: TAP_W] = tap_reg;
  end

  assign busy       = busy_reg;
  assign done       = (state_reg == ST_DONE);
  assign rd_en      = (state_reg == ST_FETCH) && (fetch_cnt_reg < TAP_CNT);
  assign rd_addr    = fetch_addr_reg;
  assign win_valid  = (state_reg == ST_ISSUE);
  assign win_kernel = kernel_reg;
  assign wr_en      = ((state_reg == ST_SCAN) && border) || (state_reg == ST_WRITE);
  assign wr_addr    = p;
  assign wr_data    = (state_reg == ST_WRITE) ? res_reg : 8'd0;

endmodule

// File: tb/tb_edge_frame_scheduler.sv
// Randomized scoreboard bench: a raster-order frame model predicts windows and writes.
module tb_edge_frame_scheduler;

  localparam int W  = 6;
  localparam int H  = 5;
  localparam int N  = W * H;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          kernel_sel;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          win_valid;
  logic          win_ready;
  logic [71:0]   win_data;
  logic          win_kernel;
  logic          res_valid;
  logic [7:0]    res_pixel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  always #5 clk = ~clk;

  edge_frame_scheduler #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kernel_sel (kernel_sel),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_kernel (win_kernel),
    .res_valid  (res_valid),
    .res_pixel  (res_pixel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // Source frame memory: one-cycle read latency.
  logic [7:0] mem [N];
  always @(posedge clk) begin
    if (rd_en) rd_data <= (rd_addr < N) ? mem[rd_addr] : 8'h00;
  end

  typedef struct {
    int addr;
    int data;
  } wr_t;

  typedef struct {
    logic [71:0] taps;
    logic        k;
  } win_t;

  wr_t  wr_q[$];
  win_t win_q[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int force_stall = 0;

  bit          pending = 0;
  int          pend_cnt = 0;
  logic [7:0]  pend_val = 0;
  bit          prev_hold = 0;
  logic [72:0] prev_win = 0;
  bit          prev_done = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Stand-in edge engine: weighted tap sum, seeded differently per kernel.
  function automatic logic [7:0] engine_fn(input logic [71:0] taps, input logic k);
    logic [7:0] acc;
    acc = k ? 8'hA5 : 8'h3C;
    for (int t = 0; t < 9; t++) acc = acc + 8'(taps[8*t +: 8] * (t + 1));
    return acc;
  endfunction

  task automatic build_frame(input logic k);
    logic [71:0] t;
    wr_t  e;
    win_t w;
    for (int p = 0; p < N; p++) begin
      int r;
      int c;
      r = p / W;
      c = p % W;
      e.addr = p;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
        e.data = 0;
      end else begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            t[8*(rr*3+cc) +: 8] = mem[(r + rr - 1) * W + (c + cc - 1)];
        w.taps = t;
        w.k    = k;
        win_q.push_back(w);
        e.data = int'(engine_fn(t, k));
      end
      wr_q.push_back(e);
    end
  endtask

  // Monitor plus engine model, both evaluated on the falling edge.
  initial begin
    wr_t  e;
    win_t w;
    forever begin
      @(negedge clk);
      chk("exclusive", 128'((int'(rd_en) + int'(win_valid) + int'(wr_en)) > 1), 0);
      if (rd_en) chk("rd_addr_range", 128'(rd_addr < N), 1);
      if (prev_hold && win_valid) chk("win_stable", {win_kernel, win_data}, prev_win);
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0h, no write expected", wr_addr, wr_data);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
      if (done) begin
        chk("done_single", prev_done, 0);
        chk("done_all_written", wr_q.size(), 0);
        done_seen++;
      end
      prev_done = done;
      if (!rst) begin
        win_ready = 0;
        res_valid = 0;
        pending   = 0;
        prev_hold = 0;
        continue;
      end
      if (force_stall > 0 && win_valid) begin
        win_ready = 0;
        force_stall--;
      end else begin
        win_ready = ($urandom_range(0, 3) != 0);
      end
      if (pending) begin
        pend_cnt--;
        res_valid = (pend_cnt == 0);
        res_pixel = (pend_cnt == 0) ? pend_val : 8'($urandom);
        if (pend_cnt == 0) pending = 0;
      end else begin
        // Stray results outside WAIT_RES must have no effect.
        res_valid = ($urandom_range(0, 7) == 0);
        res_pixel = 8'($urandom);
      end
      if (win_valid && win_ready) begin
        if (win_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: data %0h, no window expected", win_data);
        end else begin
          w = win_q.pop_front();
          chk("win_data", win_data, w.taps);
          chk("win_kernel", win_kernel, w.k);
        end
        pending  = 1;
        pend_cnt = $urandom_range(1, 4);
        pend_val = engine_fn(win_data, win_kernel);
      end
      prev_hold = win_valid && !win_ready;
      prev_win  = {win_kernel, win_data};
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_frame(input logic k, input int stall);
    int base;
    int cyc;
    fill_mem();
    build_frame(k);
    force_stall = stall;
    @(negedge clk); #2;
    start = 1;
    kernel_sel = k;
    @(negedge clk); #2;
    start = 0;
    kernel_sel = 1'($urandom);
    chk("busy_after_start", busy, 1);
    base = done_seen;
    cyc = 0;
    while (done_seen == base && cyc < 4000) begin
      @(negedge clk); #2;
      start = busy && ($urandom_range(0, 9) == 0);
      kernel_sel = 1'($urandom);
      cyc++;
    end
    chk("frame_done_count", done_seen - base, 1);
    chk("windows_consumed", win_q.size(), 0);
    // A start coinciding with done must not launch another frame.
    start = done;
    @(negedge clk); #2;
    start = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("idle_after_done", {busy, rd_en, wr_en}, 0);
    wr_q.delete();
    win_q.delete();
  endtask

  task automatic abort_frame();
    int base;
    int cyc;
    fill_mem();
    build_frame(0);
    base = done_seen;
    @(negedge clk); #2;
    start = 1;
    kernel_sel = 0;
    @(negedge clk); #2;
    start = 0;
    cyc = 0;
    while (!rd_en && cyc < 200) begin
      @(negedge clk); #2;
      cyc++;
    end
    chk("fetch_reached", rd_en, 1);
    chk("fetch_first_addr", rd_addr, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("abort_outputs_zero",
        {busy, done, rd_en, rd_addr, win_valid, win_data, win_kernel, wr_en, wr_addr, wr_data}, 0);
    wr_q.delete();
    win_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_seen - base, 0);
    #2;
    rst = 1;
  endtask

  initial begin
    rst = 1;
    start = 0;
    kernel_sel = 0;
    win_ready = 0;
    res_valid = 0;
    res_pixel = 0;
    #1 rst = 0;
    #11;
    chk("reset_outputs",
        {busy, done, rd_en, rd_addr, win_valid, win_data, win_kernel, wr_en, wr_addr, wr_data}, 0);
    @(negedge clk); #2;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_no_busy", busy, 0);

    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(0, 20);
    abort_frame();
    run_frame(1, 0);
    for (int i = 0; i < 4; i++) run_frame(1'($urandom_range(0, 1)), (i == 2) ? 25 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
